// File: rtl/png_byte_buffer.sv
// Byte-serial shift buffer that holds one complete PNG file image and
// streams it head-byte-first into the decoder's ibyte/ivalid/iready port.
// It also produces the decoder start pulse and an end-of-file done pulse.
module png_byte_buffer #(
  parameter int NBYTES = 69,
  parameter int CW     = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [8*NBYTES-1:0]   data_in,
  input  logic                  shift,
  input  logic                  iready,
  output logic [7:0]            data_out,
  output logic                  ostart,
  output logic                  ovalid,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  done
);

  localparam int W = 8 * NBYTES;

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          xfer;

  // The head byte is always the top of the register. Once every byte has
  // been shifted out, zero fill makes the head read 00 with no extra mux.
  assign data_out = sr[W-1 -: 8];
  assign count    = cnt;
  assign empty    = (cnt == '0);

  // No byte is offered during the start pulse, so the decoder sees istart
  // strictly before its first ivalid. iready only gates the transfer and
  // never feeds back into ovalid.
  assign ovalid   = shift & ~empty & ~ostart;
  assign xfer     = ovalid & iready;

  // Storage, byte counter and the two pulses. Priority is reset, then load, then transfer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr     <= '0;
      cnt    <= '0;
      ostart <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      sr     <= data_in;
      cnt    <= CW'(NBYTES);
      ostart <= 1'b1;
      done   <= 1'b0;
    end else begin
      ostart <= 1'b0;
      done   <= xfer && (cnt == CW'(1));
      if (xfer) begin
        sr  <= {sr[W-9:0], 8'h00};
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_png_byte_buffer.sv
// Directed bench for png_byte_buffer: reset, load, full stream,
// backpressure with shift gaps, reload mid-stream and reset mid-stream.
module tb_png_byte_buffer;

  localparam int NBYTES = 69;
  localparam int CW     = 7;
  localparam int W      = 8 * NBYTES;

  logic          clk;
  logic          rstn;
  logic          load;
  logic [W-1:0]  data_in;
  logic          shift;
  logic          iready;
  logic [7:0]    data_out;
  logic          ostart;
  logic          ovalid;
  logic [CW-1:0] count;
  logic          empty;
  logic          done;

  int n_chk;
  int n_fail;

  logic [W-1:0] img;
  logic [W-1:0] img2;

  png_byte_buffer #(.NBYTES(NBYTES), .CW(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .data_in  (data_in),
    .shift    (shift),
    .iready   (iready),
    .data_out (data_out),
    .ostart   (ostart),
    .ovalid   (ovalid),
    .count    (count),
    .empty    (empty),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [W-1:0] im, input int i);
    return im[8*(NBYTES-1-i) +: 8];
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'h00);
    chk({tag, "_ovalid"},   32'(ovalid),   32'h0);
    chk({tag, "_empty"},    32'(empty),    32'h1);
    chk({tag, "_count"},    32'(count),    32'h0);
    chk({tag, "_ostart"},   32'(ostart),   32'h0);
    chk({tag, "_done"},     32'(done),     32'h0);
  endtask

  // Load an image and step past the start pulse; checks the pulse itself.
  task automatic load_and_start(input logic [W-1:0] im, input string tag);
    load    = 1'b1;
    data_in = im;
    tick();
    load    = 1'b0;
    shift   = 1'b1;
    iready  = 1'b1;
    chk({tag, "_ld_head"},   32'(data_out), 32'(byte_of(im, 0)));
    chk({tag, "_ld_count"},  32'(count),    NBYTES);
    chk({tag, "_ld_ostart"}, 32'(ostart),   32'h1);
    chk({tag, "_ld_ovalid"}, 32'(ovalid),   32'h0);
    tick();
    chk({tag, "_ostart_fall"}, 32'(ostart), 32'h0);
    chk({tag, "_ovalid_up"},   32'(ovalid), 32'h1);
  endtask

  initial begin
    int k;
    int cyc;
    int done_seen;

    n_chk  = 0;
    n_fail = 0;
    img = 552'h89504E470D0A1A0A_0000000D49484452_0000000100000001_0802000000907753DE_0000000C49444154_08D763F8CFC0000003010100_18DD8DB0_0000000049454E44AE426082;
    for (int i = 0; i < NBYTES; i++) img2[8*(NBYTES-1-i) +: 8] = 8'(i * 3 + 1);

    rstn    = 1'b0;
    load    = 1'b0;
    data_in = '0;
    shift   = 1'b0;
    iready  = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    check_reset_state("rst");
    rstn = 1'b1;

    // Empty buffer ignores shift/iready.
    shift  = 1'b1;
    iready = 1'b1;
    chk("empty_ovalid", 32'(ovalid), 32'h0);
    tick();
    chk("empty_count", 32'(count), 32'h0);
    chk("empty_done",  32'(done),  32'h0);

    // Full stream at one byte per clock.
    load_and_start(img, "full");
    done_seen = 0;
    for (int i = 0; i < NBYTES; i++) begin
      chk($sformatf("full_byte%0d", i), 32'(data_out), 32'(byte_of(img, i)));
      chk($sformatf("full_cnt%0d", i),  32'(count),    32'(NBYTES - i));
      if (done) done_seen++;
      tick();
    end
    chk("full_done_early", 32'(done_seen), 32'h0);
    chk("full_empty",    32'(empty),    32'h1);
    chk("full_done",     32'(done),     32'h1);
    chk("full_data_out", 32'(data_out), 32'h00);
    chk("full_ovalid",   32'(ovalid),   32'h0);
    tick();
    chk("full_done_fall", 32'(done), 32'h0);

    // Backpressure 1,0,0,1 plus a two-cycle shift gap; bounded cycle budget.
    load_and_start(img, "bp");
    k   = 0;
    cyc = 0;
    while (k < NBYTES && cyc < 400) begin
      iready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      shift  = !(cyc == 50 || cyc == 51);
      #1;
      chk($sformatf("bp_byte_c%0d", cyc),   32'(data_out), 32'(byte_of(img, k)));
      chk($sformatf("bp_ovalid_c%0d", cyc), 32'(ovalid),   32'(shift));
      chk($sformatf("bp_count_c%0d", cyc),  32'(count),    32'(NBYTES - k));
      tick();
      if (shift && iready) k++;
      cyc++;
    end
    chk("bp_transfers", 32'(k), NBYTES);
    chk("bp_empty",     32'(empty), 32'h1);
    chk("bp_done",      32'(done),  32'h1);
    shift  = 1'b1;
    iready = 1'b1;
    tick();

    // Reload after ten bytes: restart at byte 0 of the new image.
    load_and_start(img, "rl0");
    for (int i = 0; i < 10; i++) tick();
    chk("rl_pre_byte", 32'(data_out), 32'(byte_of(img, 10)));
    load    = 1'b1;
    data_in = img2;
    tick();
    load = 1'b0;
    chk("rl_head",   32'(data_out), 32'(byte_of(img2, 0)));
    chk("rl_count",  32'(count),    NBYTES);
    chk("rl_ostart", 32'(ostart),   32'h1);
    chk("rl_ovalid", 32'(ovalid),   32'h0);
    tick();
    chk("rl_ostart_fall", 32'(ostart), 32'h0);
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("rl_byte%0d", i), 32'(data_out), 32'(byte_of(img2, i)));
      tick();
    end

    // Reset mid-stream at byte 30.
    chk("mid_byte30", 32'(data_out), 32'(byte_of(img2, 30)));
    rstn = 1'b0;
    tick();
    check_reset_state("midrst");
    rstn = 1'b1;
    tick();
    chk("midrst_hold_count", 32'(count), 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/png_byte_buffer.md
# png_byte_buffer

Parallel-load, byte-serial shift buffer that holds one complete small PNG file (default 69 bytes) and streams it MSB-byte-first into the PNG decoder's byte input (`ibyte`/`ivalid`/`iready`). It sits between the host or test loader and the `hard_png` decoder. It generates the decoder's one-cycle start pulse and handles the per-byte ready/valid handshake.

## Interface
Parameters:
- NBYTES, 69, buffer capacity in bytes; the load word is 8*NBYTES bits.
- CW, 7, byte-counter width; must satisfy 2^CW > NBYTES.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  reset; synchronous, active-low.
- load  in  1  capture `data_in` this cycle.
- data_in  in  8*NBYTES  file image; byte 0 is `data_in[8*NBYTES-1 -: 8]`.
- shift  in  1  streaming enable from the controller.
- iready  in  1  downstream (decoder) ready.
- data_out  out  8  current head byte; drives decoder `ibyte`.
- ostart  out  1  one-cycle start pulse; drives decoder `istart`.
- ovalid  out  1  head byte valid; drives decoder `ivalid`.
- count  out  CW  bytes remaining in the buffer.
- empty  out  1  `count == 0`.
- done  out  1  one-cycle pulse after the last byte is transferred.

## Operation
- Storage is an 8*NBYTES-bit shift register `sr` plus a down-counter `cnt`.
- `data_out = sr[8*NBYTES-1 -: 8]` (combinational from the register).
- `count = cnt`.
- `empty = (cnt == 0)`.
- `ovalid = shift & ~empty & ~ostart`. No byte is offered during the start pulse.
- A transfer occurs in any cycle where `ovalid & iready` is true.
- On a transfer:
  - `sr <= sr << 8`, with zero fill in the low byte.
  - `cnt <= cnt - 1`.
- Load:
  - `sr <= data_in`, `cnt <= NBYTES`, `ostart <= 1` on the next cycle.
  - Any stream in progress is discarded.
- Priority: reset > load > transfer. A transfer in the same cycle as `load` is ignored; the byte is not consumed.
- `ostart` is registered and high for exactly one cycle: the cycle after `load`. Repeated back-to-back loads give one pulse per load cycle.
- `done` is registered. It is high for one cycle after a transfer that takes `cnt` from 1 to 0.
- When the buffer is empty:
  - `data_out = 0`, `ovalid = 0`.
  - `shift` and `iready` have no effect.
- `shift` low holds all state. `data_out` remains stable.
- Byte order is MSB-first, so a PNG image emits 89 50 4E 47 … in file order.

## Timing
- Reset (rstn low at a clock edge): `sr = 0`, `cnt = 0`, `ostart = 0`, `done = 0`.
  - Outputs after reset: `data_out = 00`, `ovalid = 0`, `empty = 1`, `count = 0`.
  - Reset in mid-stream aborts the transfer immediately.
- Load at edge N:
  - From N, `data_out` = byte 0, `count` = NBYTES, and `ostart` = 1 for the cycle N..N+1.
  - `ovalid` can first be high in the cycle after `ostart` falls.
- Throughput is one byte per clock while `shift & iready` stays high.
- Latency from first `ovalid` to last byte is NBYTES cycles.
- When `iready` is low, `data_out` and `ovalid` hold; no byte is lost or duplicated.
- `ovalid` does not depend combinationally on `iready`, so there is no loop through the decoder.
- Counter arithmetic is unsigned CW bits. It never underflows because transfers are gated by `~empty`.

## Test plan
- Reset: hold rstn=0 for 2 cycles → `data_out=00`, `ovalid=0`, `empty=1`, `count=0`, `ostart=0`, `done=0`.
- Load the 69-byte 1×1 RGB PNG image (`89504E47…AE426082`) → next cycle `data_out=89`, `count=69`, `ostart=1` for exactly one cycle, `ovalid=0` during the pulse.
- Stream with shift=1, iready=1 → bytes 89,50,4E,47,0D,0A,1A,0A,…,AE,42,60,82 on 69 consecutive cycles → then `empty=1`, `done` pulses once, `data_out=00`.
- Backpressure: toggle iready 1,0,0,1 mid-stream → `data_out` held while iready=0, with no skipped or repeated byte; total transfers = 69.
- Load during streaming after 10 bytes → buffer restarts at byte 0, `count=69`, a new `ostart` pulse, no transfer in the load cycle.
- Reset mid-stream (rstn=0 at byte 30) → next cycle all outputs at reset values. With `hard_png` attached after a full stream → decoder reports colortype=2, width=1, height=1.
